lfsr_stream_checker: RTL and testbench

//  Receive-side checker for the 32-bit LFSR word stream produced by the LFSR generator stages.

---
 rtl/lfsr_pkg.sv | 18 +
 rtl/lfsr_stream_checker.sv | 117 +++++++++++
 tb/tb_lfsr_stream_checker.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the word-stream generator and checker.
// Both ends use lfsr_next, so they always agree on the sequence.
package lfsr_pkg;

  localparam logic [31:0] LFSR_TAPS_DEFAULT = 32'h8020_0003;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } lfsr_chk_state_t;

  // Shift left by one and feed the parity of the tapped bits into bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
    return {s[30:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/lfsr_stream_checker.sv
// Receive-side LFSR stream checker: hunts for a seed, verifies LOCK_MATCHES predictions,
// then counts mismatches until LOSS_MISSES consecutive misses force a resync.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter logic [31:0] TAPS         = LFSR_TAPS_DEFAULT,
  parameter int          LOCK_MATCHES = 4,
  parameter int          LOSS_MISSES  = 3,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             data_valid,
  input  logic [31:0]      data,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [7:0] LOCK_N = 8'(LOCK_MATCHES);
  localparam logic [7:0] LOSS_N = 8'(LOSS_MISSES);

  lfsr_chk_state_t  r_state;
  logic [31:0]      r_expected;
  logic [7:0]       r_match_run;
  logic [7:0]       r_miss_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_word_cnt;

  logic [31:0] w_next_exp;
  logic [31:0] w_next_data;
  logic        w_match;

  assign w_next_exp  = lfsr_next(r_expected, TAPS);
  assign w_next_data = lfsr_next(data, TAPS);
  assign w_match     = (data == r_expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= HUNT;
      r_expected  <= '0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
    end else if (clr) begin
      r_state     <= HUNT;
      r_expected  <= '0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      if (data_valid) begin
        case (r_state)
          HUNT: begin
            // Zero is the LFSR lockup state and can never seed a real stream.
            if (data != '0) begin
              r_expected  <= w_next_data;
              r_match_run <= '0;
              r_state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (w_match) begin
              r_match_run <= r_match_run + 8'd1;
              r_expected  <= w_next_exp;
              if (r_match_run + 8'd1 == LOCK_N) begin
                r_state    <= LOCKED;
                r_locked   <= 1'b1;
                r_miss_run <= '0;
              end
            end else begin
              r_expected  <= w_next_data;
              r_match_run <= '0;
            end
          end
          LOCKED: begin
            // Prediction free-runs from itself so isolated bit errors cannot desync it.
            r_expected <= w_next_exp;
            if (~&r_word_cnt) r_word_cnt <= r_word_cnt + 1'b1;
            if (w_match) begin
              r_miss_run <= '0;
            end else begin
              r_err_pulse <= 1'b1;
              if (~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
              r_miss_run <= r_miss_run + 8'd1;
              if (r_miss_run + 8'd1 == LOSS_N) begin
                r_locked    <= 1'b0;
                r_state     <= HUNT;
                r_match_run <= '0;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign word_cnt  = r_word_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: a hand-computed vector table plus multi-cycle sequences.
// A second instance with 4-bit counters exercises saturation in a reasonable number of cycles.
module tb_lfsr_stream_checker;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        data_valid;
  logic [31:0] data;

  logic        locked, err_pulse;
  logic [15:0] err_cnt, word_cnt;
  logic [1:0]  dbg_state;

  logic        locked_s, err_pulse_s;
  logic [3:0]  err_cnt_s, word_cnt_s;
  logic [1:0]  dbg_state_s;

  int total = 0;
  int bad   = 0;

  lfsr_stream_checker dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .data_valid(data_valid), .data(data),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .word_cnt(word_cnt),
    .dbg_state(dbg_state)
  );

  lfsr_stream_checker #(.CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .clr(clr), .data_valid(data_valid), .data(data),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s), .word_cnt(word_cnt_s),
    .dbg_state(dbg_state_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the step: feedback is the XOR of bits 31, 21, 1 and 0.
  function automatic logic [31:0] tb_next(input logic [31:0] s);
    logic fb;
    fb = s[31] ^ s[21] ^ s[1] ^ s[0];
    return {s[30:0], fb};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; the rising edge samples them; outputs are read
  // on the following falling edge.
  task automatic drive(input logic v, input logic [31:0] d);
    data_valid = v;
    data       = d;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Feed seed plus four correct words; lock must appear only after the fifth.
  task automatic lock_seq(input logic [31:0] seed, input string nm, output logic [31:0] nxt);
    logic [31:0] w;
    w = seed;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, w);
      if (i == 3) chk({nm, "_prelock"}, {31'd0, locked}, 32'd0);
      w = tb_next(w);
    end
    chk({nm, "_locked"}, {31'd0, locked}, 32'd1);
    nxt = w;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        e_lock;
    logic        e_pulse;
    logic [15:0] e_err;
    logic [15:0] e_wc;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] w;
    int pulses;

    // Words 1,3,6,D,1B,36,6D,DB,1B6,36D follow from the tap mask by hand.
    tbl[0]  = '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{1'b1, 32'h0000_0003, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{1'b1, 32'h0000_0006, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{1'b1, 32'h0000_000D, 1'b0, 1'b0, 16'd0, 16'd0};
    tbl[4]  = '{1'b1, 32'h0000_001B, 1'b1, 1'b0, 16'd0, 16'd0};
    tbl[5]  = '{1'b1, 32'h0000_0036, 1'b1, 1'b0, 16'd0, 16'd1};
    tbl[6]  = '{1'b1, 32'h0000_006D, 1'b1, 1'b0, 16'd0, 16'd2};
    tbl[7]  = '{1'b1, 32'h0000_00FB, 1'b1, 1'b1, 16'd1, 16'd3};  // 0xDB with bit 5 flipped
    tbl[8]  = '{1'b1, 32'h0000_01B6, 1'b1, 1'b0, 16'd1, 16'd4};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 16'd1, 16'd4};
    tbl[10] = '{1'b1, 32'h0000_036D, 1'b1, 1'b0, 16'd1, 16'd5};

    rst_n = 1'b0; clr = 1'b0; data_valid = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err", {16'd0, err_cnt}, 32'd0);
    chk("rst_wc", {16'd0, word_cnt}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tests 1-2: lock point and a single bit error while locked
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_lock", i), {31'd0, locked}, {31'd0, tbl[i].e_lock});
      chk($sformatf("tbl%0d_pulse", i), {31'd0, err_pulse}, {31'd0, tbl[i].e_pulse});
      chk($sformatf("tbl%0d_err", i), {16'd0, err_cnt}, {16'd0, tbl[i].e_err});
      chk($sformatf("tbl%0d_wc", i), {16'd0, word_cnt}, {16'd0, tbl[i].e_wc});
    end
    drive(1'b0, '0);
    chk("t2_pulse_width", {31'd0, err_pulse}, 32'd0);

    // Test 3: three consecutive misses drop lock, then a new seed relocks
    do_clr();
    lock_seq(32'hA5A5_0001, "t3a", w);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w ^ 32'h0000_0100);
      w = tb_next(w);
      chk($sformatf("t3_pulse%0d", i), {31'd0, err_pulse}, 32'd1);
      chk($sformatf("t3_lock%0d", i), {31'd0, locked}, (i == 2) ? 32'd0 : 32'd1);
    end
    chk("t3_err", {16'd0, err_cnt}, 32'd3);
    chk("t3_state", {30'd0, dbg_state}, 32'd0);
    lock_seq(32'hCAFE_0001, "t3b", w);

    // Test 4: zeros are ignored in HUNT
    do_clr();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h0);
      pulses += int'(err_pulse);
      chk($sformatf("t4_hunt%0d", i), {30'd0, dbg_state}, 32'd0);
    end
    chk("t4_lock", {31'd0, locked}, 32'd0);
    chk("t4_pulses", pulses, 32'd0);
    lock_seq(32'h1234_FADC, "t4", w);

    // Test 5: one valid word every third cycle
    do_clr();
    w = 32'h0BAD_F00D;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, w);
      w = tb_next(w);
      if (i == 3) chk("t5_prelock", {31'd0, locked}, 32'd0);
      if (i == 4) chk("t5_lock", {31'd0, locked}, 32'd1);
      drive(1'b0, 32'hFFFF_FFFF);
      drive(1'b0, 32'h0);
    end
    chk("t5_wc", {16'd0, word_cnt}, 32'd3);
    chk("t5_err", {16'd0, err_cnt}, 32'd0);

    // Test 6a: asynchronous reset mid-LOCKED, checked before any clock edge
    drive(1'b1, w ^ 32'h1);
    w = tb_next(w);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_lock", {31'd0, locked}, 32'd0);
    chk("t6_arst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("t6_arst_err", {16'd0, err_cnt}, 32'd0);
    chk("t6_arst_wc", {16'd0, word_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lock_seq(32'h5555_AAAA, "t6", w);

    // Test 6b: clr wins over a valid word
    clr = 1'b1;
    drive(1'b1, w ^ 32'h1);
    clr = 1'b0;
    chk("t6_clr_lock", {31'd0, locked}, 32'd0);
    chk("t6_clr_pulse", {31'd0, err_pulse}, 32'd0);
    chk("t6_clr_wc", {16'd0, word_cnt}, 32'd0);
    chk("t6_clr_state", {30'd0, dbg_state}, 32'd0);

    // Test 6c: counter saturation on the 4-bit instance
    lock_seq(32'h0000_0F0F, "t6s", w);
    chk("t6s_small_lock", {31'd0, locked_s}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, w ^ 32'h8000_0000);
      w = tb_next(w);
      if (i == 16) chk("t6s_pulse_sat", {31'd0, err_pulse_s}, 32'd1);
      drive(1'b1, w);
      w = tb_next(w);
    end
    chk("t6s_err_main", {16'd0, err_cnt}, 32'd17);
    chk("t6s_wc_main", {16'd0, word_cnt}, 32'd34);
    chk("t6s_err_small", {28'd0, err_cnt_s}, 32'd15);
    chk("t6s_wc_small", {28'd0, word_cnt_s}, 32'd15);
    chk("t6s_lock_small", {31'd0, locked_s}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
